// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM tile scheduler: FSM encoding, default tile geometry
// and a counter-width helper.
package gemm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StStream,
        StDrain,
        StWrite,
        StDone
    } state_e;

    localparam int unsigned DefPeSize        = 14;
    localparam int unsigned DefKTiles        = 21;
    localparam int unsigned DefNTiles        = 5;
    localparam int unsigned DefStreamLen     = 196;
    localparam int unsigned DefDrainLat      = 27;
    localparam int unsigned DefWrLen         = 14;
    localparam int unsigned DefMem0AddrWidth = 13;
    localparam int unsigned DefMem1AddrWidth = 11;
    localparam int unsigned DefMem2AddrWidth = 10;

    // Width of a counter holding 0..max_val-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/tile_cnt.sv
// Modulo-MAX tile counter with synchronous clear; wrap flags the increment that returns to 0.
module tile_cnt #(
    parameter int unsigned MAX   = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_q;

    assign cnt  = cnt_q;
    assign wrap = inc && (cnt_q == WIDTH'(MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= wrap ? '0 : cnt_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Sequences weight loads, ifmap streaming, drain and ofmap write-back for a tiled GEMM
// on a systolic array; all BRAM-side and status outputs are registered.
module gemm_tile_scheduler
    import gemm_pkg::*;
#(
    parameter int unsigned PE_SIZE         = DefPeSize,
    parameter int unsigned K_TILES         = DefKTiles,
    parameter int unsigned N_TILES         = DefNTiles,
    parameter int unsigned STREAM_LEN      = DefStreamLen,
    parameter int unsigned DRAIN_LAT       = DefDrainLat,
    parameter int unsigned WR_LEN          = DefWrLen,
    parameter int unsigned MEM0_ADDR_WIDTH = DefMem0AddrWidth,
    parameter int unsigned MEM1_ADDR_WIDTH = DefMem1AddrWidth,
    parameter int unsigned MEM2_ADDR_WIDTH = DefMem2AddrWidth
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    output logic                          mem1_ce0,
    output logic                          mem1_we0,
    output logic [MEM1_ADDR_WIDTH-1:0]    mem1_addr0,
    output logic                          mem0_ce0,
    output logic                          mem0_we0,
    output logic [MEM0_ADDR_WIDTH-1:0]    mem0_addr0,
    output logic                          mem2_ce0,
    output logic                          mem2_we0,
    output logic [MEM2_ADDR_WIDTH-1:0]    mem2_addr0,
    output logic                          w_load_o,
    output logic                          ifmap_vld_o,
    output logic                          psum_clr_o,
    output logic [cnt_width(WR_LEN)-1:0]  acc_sel_o,
    output logic                          busy_o,
    output logic                          finish_o
);

    localparam int unsigned NW = cnt_width(N_TILES);
    localparam int unsigned KW = cnt_width(K_TILES);
    localparam int unsigned IW = cnt_width(PE_SIZE);
    localparam int unsigned JW = cnt_width(STREAM_LEN);
    localparam int unsigned DW = cnt_width(DRAIN_LAT);
    localparam int unsigned WW = cnt_width(WR_LEN);

    state_e state_q, state_d;

    logic          start_run;
    logic [NW-1:0] n_cnt;
    logic [KW-1:0] k_cnt;
    logic [IW-1:0] i_cnt;
    logic [JW-1:0] j_cnt;
    logic [DW-1:0] d_cnt;
    logic [WW-1:0] w_cnt;
    logic          n_wrap, k_wrap, i_wrap, j_wrap, d_wrap, w_wrap;

    assign start_run = (state_q == StIdle) && start_i;

    // k and n advance on the last cycle of DRAIN / WRITE, so their wrap flags mark the
    // final K tile and the final N tile respectively.
    tile_cnt #(.MAX(N_TILES), .WIDTH(NW)) u_n_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_run), .inc(w_wrap), .cnt(n_cnt), .wrap(n_wrap)
    );
    tile_cnt #(.MAX(K_TILES), .WIDTH(KW)) u_k_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_run), .inc(d_wrap), .cnt(k_cnt), .wrap(k_wrap)
    );
    tile_cnt #(.MAX(PE_SIZE), .WIDTH(IW)) u_i_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_run), .inc(state_q == StLoadW),
        .cnt(i_cnt), .wrap(i_wrap)
    );
    tile_cnt #(.MAX(STREAM_LEN), .WIDTH(JW)) u_j_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_run), .inc(state_q == StStream),
        .cnt(j_cnt), .wrap(j_wrap)
    );
    tile_cnt #(.MAX(DRAIN_LAT), .WIDTH(DW)) u_d_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_run), .inc(state_q == StDrain),
        .cnt(d_cnt), .wrap(d_wrap)
    );
    tile_cnt #(.MAX(WR_LEN), .WIDTH(WW)) u_w_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_run), .inc(state_q == StWrite),
        .cnt(w_cnt), .wrap(w_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_i) state_d = StLoadW;
            StLoadW:  if (i_wrap) state_d = StStream;
            StStream: if (j_wrap) state_d = StDrain;
            StDrain:  if (d_wrap) state_d = k_wrap ? StWrite : StLoadW;
            StWrite:  if (w_wrap) state_d = n_wrap ? StDone : StLoadW;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    logic                       mem1_ce_d, mem1_ce_q, mem0_ce_d, mem0_ce_q, mem2_ce_d, mem2_ce_q;
    logic [MEM1_ADDR_WIDTH-1:0] mem1_addr_d, mem1_addr_q;
    logic [MEM0_ADDR_WIDTH-1:0] mem0_addr_d, mem0_addr_q;
    logic [MEM2_ADDR_WIDTH-1:0] mem2_addr_d, mem2_addr_q;
    logic [WW-1:0]              acc_sel_d, acc_sel_q;
    logic                       psum_clr_d, psum_clr_q, busy_d, busy_q, finish_d, finish_q;
    logic                       w_load_q, ifmap_vld_q;

    // Addresses are formed at 32 bits and truncated to the port width.
    always_comb begin
        mem1_ce_d   = 1'b0;
        mem1_addr_d = '0;
        mem0_ce_d   = 1'b0;
        mem0_addr_d = '0;
        mem2_ce_d   = 1'b0;
        mem2_addr_d = '0;
        acc_sel_d   = '0;
        psum_clr_d  = 1'b0;
        busy_d      = state_q inside {StLoadW, StStream, StDrain, StWrite};
        finish_d    = (state_q == StDone);
        unique case (state_q)
            StLoadW: begin
                mem1_ce_d   = 1'b1;
                mem1_addr_d = MEM1_ADDR_WIDTH'((32'(n_cnt) * K_TILES + 32'(k_cnt)) * PE_SIZE
                                               + 32'(i_cnt));
            end
            StStream: begin
                mem0_ce_d   = 1'b1;
                mem0_addr_d = MEM0_ADDR_WIDTH'(32'(k_cnt) * STREAM_LEN + 32'(j_cnt));
                psum_clr_d  = (j_cnt == '0) && (k_cnt == '0);
            end
            StWrite: begin
                mem2_ce_d   = 1'b1;
                mem2_addr_d = MEM2_ADDR_WIDTH'(32'(n_cnt) * WR_LEN + 32'(w_cnt));
                acc_sel_d   = w_cnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem1_ce_q   <= 1'b0;
            mem1_addr_q <= '0;
            mem0_ce_q   <= 1'b0;
            mem0_addr_q <= '0;
            mem2_ce_q   <= 1'b0;
            mem2_addr_q <= '0;
            acc_sel_q   <= '0;
            psum_clr_q  <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            w_load_q    <= 1'b0;
            ifmap_vld_q <= 1'b0;
        end else begin
            mem1_ce_q   <= mem1_ce_d;
            mem1_addr_q <= mem1_addr_d;
            mem0_ce_q   <= mem0_ce_d;
            mem0_addr_q <= mem0_addr_d;
            mem2_ce_q   <= mem2_ce_d;
            mem2_addr_q <= mem2_addr_d;
            acc_sel_q   <= acc_sel_d;
            psum_clr_q  <= psum_clr_d;
            busy_q      <= busy_d;
            finish_q    <= finish_d;
            // Read data arrives one cycle after the BRAM enable.
            w_load_q    <= mem1_ce_q;
            ifmap_vld_q <= mem0_ce_q;
        end
    end

    assign mem1_ce0    = mem1_ce_q;
    assign mem1_we0    = 1'b0;
    assign mem1_addr0  = mem1_addr_q;
    assign mem0_ce0    = mem0_ce_q;
    assign mem0_we0    = 1'b0;
    assign mem0_addr0  = mem0_addr_q;
    assign mem2_ce0    = mem2_ce_q;
    assign mem2_we0    = mem2_ce_q;
    assign mem2_addr0  = mem2_addr_q;
    assign acc_sel_o   = acc_sel_q;
    assign psum_clr_o  = psum_clr_q;
    assign busy_o      = busy_q;
    assign finish_o    = finish_q;
    assign w_load_o    = w_load_q;
    assign ifmap_vld_o = ifmap_vld_q;

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench: a small configuration checked against a table of expected BRAM accesses,
// plus start-hold, mid-run reset and a full default-size run.
module tb_gemm_tile_scheduler;

    localparam int unsigned P = 4;
    localparam int unsigned K = 2;
    localparam int unsigned N = 2;
    localparam int unsigned S = 3;
    localparam int unsigned D = 2;
    localparam int unsigned W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, start_def;

    logic        m1_ce, m1_we, m0_ce, m0_we, m2_ce, m2_we;
    logic [10:0] m1_addr;
    logic [12:0] m0_addr;
    logic [9:0]  m2_addr;
    logic        w_load, ifmap_vld, psum_clr, busy, finish;
    logic [0:0]  acc_sel;

    logic        d_m1_ce, d_m1_we, d_m0_ce, d_m0_we, d_m2_ce, d_m2_we;
    logic [10:0] d_m1_addr;
    logic [12:0] d_m0_addr;
    logic [9:0]  d_m2_addr;
    logic        d_w_load, d_ifmap_vld, d_psum_clr, d_busy, d_finish;
    logic [3:0]  d_acc_sel;

    gemm_tile_scheduler #(
        .PE_SIZE(P), .K_TILES(K), .N_TILES(N), .STREAM_LEN(S), .DRAIN_LAT(D), .WR_LEN(W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .mem1_ce0(m1_ce), .mem1_we0(m1_we), .mem1_addr0(m1_addr),
        .mem0_ce0(m0_ce), .mem0_we0(m0_we), .mem0_addr0(m0_addr),
        .mem2_ce0(m2_ce), .mem2_we0(m2_we), .mem2_addr0(m2_addr),
        .w_load_o(w_load), .ifmap_vld_o(ifmap_vld), .psum_clr_o(psum_clr),
        .acc_sel_o(acc_sel), .busy_o(busy), .finish_o(finish)
    );

    gemm_tile_scheduler dut_def (
        .clk(clk), .rst_n(rst_n), .start_i(start_def),
        .mem1_ce0(d_m1_ce), .mem1_we0(d_m1_we), .mem1_addr0(d_m1_addr),
        .mem0_ce0(d_m0_ce), .mem0_we0(d_m0_we), .mem0_addr0(d_m0_addr),
        .mem2_ce0(d_m2_ce), .mem2_we0(d_m2_we), .mem2_addr0(d_m2_addr),
        .w_load_o(d_w_load), .ifmap_vld_o(d_ifmap_vld), .psum_clr_o(d_psum_clr),
        .acc_sel_o(d_acc_sel), .busy_o(d_busy), .finish_o(d_finish)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_small();
        return 64'({m1_ce, m1_we, m1_addr, m0_ce, m0_we, m0_addr, m2_ce, m2_we, m2_addr,
                    w_load, ifmap_vld, psum_clr, acc_sel, busy, finish});
    endfunction

    function automatic logic [63:0] outs_def();
        return 64'({d_m1_ce, d_m1_we, d_m1_addr, d_m0_ce, d_m0_we, d_m0_addr, d_m2_ce, d_m2_we,
                    d_m2_addr, d_w_load, d_ifmap_vld, d_psum_clr, d_acc_sel, d_busy, d_finish});
    endfunction

    // Expected BRAM access in order: port 1=weight read, 0=ifmap read, 2=ofmap write.
    typedef struct {
        string       name;
        logic [1:0]  port;
        int unsigned addr;
    } vec_t;
    vec_t tbl[$];

    typedef struct packed {
        logic [1:0]  port;
        logic [15:0] addr;
    } ev_t;
    ev_t obs[$];

    int cyc = 0, busy_len = 0, finish_cnt = 0, clr_cnt = 0, ce_events = 0;
    int run_lens[$], finish_cyc[$], rise_cyc[$];
    logic prev_m1ce = 1'b0, prev_m0ce = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            check("w_load_lag", 64'(w_load), 64'(prev_m1ce));
            check("ifmap_vld_lag", 64'(ifmap_vld), 64'(prev_m0ce));
            check("addr_zero_when_idle",
                  64'((m1_ce ? 11'd0 : m1_addr)) | 64'((m0_ce ? 13'd0 : m0_addr))
                  | 64'((m2_ce ? 10'd0 : m2_addr)), 64'(0));
            check("we_levels", 64'({m0_we, m1_we, m2_we ^ m2_ce}), 64'(0));
            check("psum_clr_pos", 64'(psum_clr), 64'(m0_ce && m0_addr == 13'd0));
            check("busy_finish_excl", 64'(busy & finish), 64'(0));
            if (m2_ce) check("acc_sel", 64'(acc_sel), 64'(m2_addr % W));
            if (finish) begin
                check("finish_after_busy", 64'(prev_busy), 64'(1));
                finish_cnt++;
                finish_cyc.push_back(cyc);
            end
            if (m1_ce) obs.push_back({2'd1, 16'(m1_addr)});
            if (m0_ce) obs.push_back({2'd0, 16'(m0_addr)});
            if (m2_ce) obs.push_back({2'd2, 16'(m2_addr)});
            if (m1_ce || m0_ce || m2_ce) ce_events++;
            if (psum_clr) clr_cnt++;
            if (busy && !prev_busy) rise_cyc.push_back(cyc);
            if (busy) busy_len++;
            if (!busy && prev_busy) begin
                run_lens.push_back(busy_len);
                busy_len = 0;
            end
            prev_m1ce = m1_ce;
            prev_m0ce = m0_ce;
            prev_busy = busy;
        end else begin
            prev_m1ce = 1'b0;
            prev_m0ce = 1'b0;
            prev_busy = 1'b0;
            busy_len  = 0;
        end
    end

    int def_busy = 0, def_finish = 0;
    int unsigned def_m1 = 0, def_m0 = 0, def_m2 = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (d_busy) def_busy++;
            if (d_finish) def_finish++;
            if (d_m1_ce) def_m1 = d_m1_addr;
            if (d_m0_ce) def_m0 = d_m0_addr;
            if (d_m2_ce) def_m2 = d_m2_addr;
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_finishes(input int target, input int budget, input string name);
        int t = 0;
        while (finish_cnt < target && t < budget) begin
            @(posedge clk);
            t++;
        end
        check(name, 64'(finish_cnt >= target), 64'(1));
    endtask

    initial begin
        int t, fc0, snap;

        for (int n = 0; n < int'(N); n++) begin
            for (int k = 0; k < int'(K); k++) begin
                for (int i = 0; i < int'(P); i++)
                    tbl.push_back('{$sformatf("w_rd n%0d k%0d i%0d", n, k, i), 2'd1,
                                    (n * K + k) * P + i});
                for (int j = 0; j < int'(S); j++)
                    tbl.push_back('{$sformatf("if_rd n%0d k%0d j%0d", n, k, j), 2'd0,
                                    k * S + j});
            end
            for (int w = 0; w < int'(W); w++)
                tbl.push_back('{$sformatf("of_wr n%0d w%0d", n, w), 2'd2, n * W + w});
        end

        rst_n = 1'b0;
        start = 1'b0;
        start_def = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs_small(), 64'(0));
        check("reset_state_def", outs_def(), 64'(0));
        rst_n = 1'b1;

        // Single run against the access table.
        repeat (2) @(posedge clk);
        check("idle_no_busy", 64'(busy), 64'(0));
        obs.delete();
        pulse_start();
        wait_finishes(1, 200, "run1_finish_timeout");
        repeat (3) @(posedge clk);
        check("ev_count", 64'(obs.size()), 64'(tbl.size()));
        for (int i = 0; i < tbl.size(); i++)
            if (i < obs.size())
                check(tbl[i].name, 64'(obs[i]), 64'({tbl[i].port, 16'(tbl[i].addr)}));
        check("run1_busy_len", 64'(run_lens.size() > 0 ? run_lens[$] : -1), 64'(40));
        check("run1_finish_pulses", 64'(finish_cnt), 64'(1));
        check("run1_clr_pulses", 64'(clr_cnt), 64'(2));

        // start held high: one run per pass through IDLE, one idle cycle between runs.
        fc0 = finish_cnt;
        snap = rise_cyc.size();
        @(posedge clk);
        #1 start = 1'b1;
        wait_finishes(fc0 + 1, 200, "held_first_timeout");
        t = 0;
        while (rise_cyc.size() < snap + 2 && t < 20) begin
            @(negedge clk);
            t++;
        end
        #1 start = 1'b0;
        check("held_second_rise", 64'(rise_cyc.size()), 64'(snap + 2));
        if (rise_cyc.size() >= snap + 2 && finish_cyc.size() > fc0)
            check("held_restart_gap", 64'(rise_cyc[snap + 1] - finish_cyc[fc0]), 64'(2));
        wait_finishes(fc0 + 2, 200, "held_second_timeout");
        repeat (10) @(posedge clk);
        check("held_run_count", 64'(finish_cnt), 64'(fc0 + 2));
        check("held_busy_low_after", 64'(busy), 64'(0));
        if (run_lens.size() >= 3) begin
            check("held_run1_len", 64'(run_lens[run_lens.size() - 2]), 64'(40));
            check("held_run2_len", 64'(run_lens[$]), 64'(40));
        end

        // Reset in the second ifmap-read cycle: outputs clear without a clock edge.
        pulse_start();
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(m0_ce && m0_addr == 13'd1) && t < 100);
        check("stream2_seen", 64'(m0_ce && m0_addr == 13'd1), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs_small(), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        snap = ce_events;
        fc0 = finish_cnt;
        repeat (20) @(posedge clk);
        check("no_ce_after_reset", 64'(ce_events - snap), 64'(0));
        check("no_finish_after_abort", 64'(finish_cnt), 64'(fc0));
        obs.delete();
        pulse_start();
        wait_finishes(fc0 + 1, 200, "rerun_finish_timeout");
        repeat (3) @(posedge clk);
        check("rerun_ev_count", 64'(obs.size()), 64'(tbl.size()));
        if (obs.size() > 0) check("rerun_first_ev", 64'(obs[0]), 64'({2'd1, 16'd0}));
        check("rerun_busy_len", 64'(run_lens.size() > 0 ? run_lens[$] : -1), 64'(40));

        // Full-size run with default parameters.
        @(posedge clk);
        #1 start_def = 1'b1;
        @(posedge clk);
        #1 start_def = 1'b0;
        t = 0;
        while (def_finish == 0 && t < 30000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        check("def_finish_pulses", 64'(def_finish), 64'(1));
        check("def_busy_cycles", 64'(def_busy), 64'(24955));
        check("def_last_mem1", 64'(def_m1), 64'(1469));
        check("def_last_mem0", 64'(def_m0), 64'(4115));
        check("def_last_mem2", 64'(def_m2), 64'(69));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gemm_tile_scheduler.md
GEMM_TILE_SCHEDULER -- requirements
Module: gemm_tile_scheduler

Interface
REQ-001 Parameter PE_SIZE, default 14, systolic array edge (words per weight tile load).
REQ-002 Parameter K_TILES, default 21, weight row tiles (WEIGHT_ROW_NUM/PE_SIZE).
REQ-003 Parameter N_TILES, default 5, weight column tiles (WEIGHT_COL_NUM/PE_SIZE).
REQ-004 Parameter STREAM_LEN, default 196, ifmap words streamed per K tile.
REQ-005 Parameter DRAIN_LAT, default 27, array drain cycles after the last ifmap word.
REQ-006 Parameter WR_LEN, default 14, ofmap words written per N tile.
REQ-007 Parameters MEM0_ADDR_WIDTH 13, MEM1_ADDR_WIDTH 11, MEM2_ADDR_WIDTH 10, BRAM address widths.
REQ-008 clk  in  1  single clock; all logic is on the rising edge.
REQ-009 rst_n  in  1  reset, asynchronous, active-low.
REQ-010 start_i  in  1  level request to run one full GEMM.
REQ-011 mem1_ce0/mem1_we0/mem1_addr0  out  1/1/MEM1_ADDR_WIDTH  weight BRAM read port.
REQ-012 mem0_ce0/mem0_we0/mem0_addr0  out  1/1/MEM0_ADDR_WIDTH  ifmap BRAM read port.
REQ-013 mem2_ce0/mem2_we0/mem2_addr0  out  1/1/MEM2_ADDR_WIDTH  ofmap BRAM write port.
REQ-014 w_load_o  out  1  weight data valid at the array (one cycle after the mem1 read).
REQ-015 ifmap_vld_o  out  1  ifmap data valid at the array (one cycle after the mem0 read).
REQ-016 psum_clr_o  out  1  clear the accumulators (one-cycle pulse).
REQ-017 acc_sel_o  out  clog2(WR_LEN)  accumulator row driven onto mem2_d0 during WRITE.
REQ-018 busy_o  out  1  high from start acceptance until finish_o.
REQ-019 finish_o  out  1  one-cycle completion pulse.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD_W, STREAM, DRAIN, WRITE and DONE.
REQ-021 In IDLE with start_i=1, the FSM SHALL reset n=0, k=0 and go to LOAD_W on the next edge; start_i SHALL be ignored in every other state.
REQ-022 In LOAD_W, for PE_SIZE cycles i=0..PE_SIZE-1, the block SHALL drive mem1_ce0=1 and mem1_addr0=(n*K_TILES+k)*PE_SIZE+i, then go to STREAM.
REQ-023 In STREAM, for STREAM_LEN cycles j, the block SHALL drive mem0_ce0=1 and mem0_addr0=k*STREAM_LEN+j, then go to DRAIN.
REQ-024 psum_clr_o SHALL pulse during the first STREAM cycle only when k=0.
REQ-025 DRAIN SHALL last DRAIN_LAT cycles; it then goes to LOAD_W with k+1 if k<K_TILES-1, otherwise to WRITE.
REQ-026 In WRITE, for WR_LEN cycles w, the block SHALL drive mem2_ce0=1, mem2_we0=1, mem2_addr0=n*WR_LEN+w and acc_sel_o=w.
REQ-027 After WRITE, the FSM SHALL go to LOAD_W with n+1 and k=0 if n<N_TILES-1, otherwise to DONE.
REQ-028 DONE SHALL last one cycle with finish_o=1, then return to IDLE.
REQ-029 w_load_o and ifmap_vld_o SHALL be mem1_ce0 and mem0_ce0 registered by one cycle (BRAM read latency 1).
REQ-030 mem0_we0 and mem1_we0 SHALL be constant 0.
REQ-031 All address outputs SHALL be registered, and SHALL be 0 whenever the corresponding ce is 0.
REQ-032 Address arithmetic SHALL be computed at full width and truncated to the port width; the parameters are constrained so that no address exceeds its BRAM depth.
REQ-033 Total busy cycles SHALL equal N_TILES*(K_TILES*(PE_SIZE+STREAM_LEN+DRAIN_LAT)+WR_LEN).

Reset
REQ-034 When rst_n=0, the FSM SHALL be in IDLE and all counters and all outputs SHALL be 0, immediately and independent of clk.
REQ-035 A reset asserted mid-operation SHALL abort the run with no further BRAM accesses; a new run SHALL require start_i after reset is released.

Structure
REQ-036 The FSM state encoding and the default tile parameters SHALL be defined in the shared package gemm_pkg.
REQ-037 The n, k, i/j/w and drain counters SHALL each be an instance of one sub-module, tile_cnt (parameterised max, inc, wrap flag).

Verification
REQ-038 Parameters PE_SIZE=4, K_TILES=2, N_TILES=2, STREAM_LEN=3, DRAIN_LAT=2, WR_LEN=2, start pulse -> busy_o high for 40 cycles, then finish_o high for exactly 1 cycle.
REQ-039 Same config -> mem1_addr0 sequence 0..15 in four bursts of 4; mem0_addr0 sequence 0,1,2,3,4,5 repeated twice; mem2_addr0 0,1 then 2,3.
REQ-040 Same config -> psum_clr_o pulses exactly twice, each time at the first STREAM cycle of k=0; w_load_o and ifmap_vld_o each lag their ce by 1 cycle.
REQ-041 start_i held high through the whole run -> exactly one run; a second run begins on the edge after DONE returns to IDLE.
REQ-042 rst_n asserted in the 2nd STREAM cycle -> all outputs read 0 without waiting for a clock edge, and no ce rises until start_i is reasserted after reset release.
REQ-043 Default parameters -> last mem1_addr0=1469, last mem0_addr0=4115, last mem2_addr0=69, finish_o after 5*(21*237+14)=24955 busy cycles.
